// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM states, widths,
// and the mapping from input combination to truth-table bit position.
package tt_sweep_pkg;

  localparam int TT_BITS = 8;
  localparam int IN_BITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_t;

  // Combination k = {in1,in2,in3} lands in tt_code[7-k], so 000 is the MSB.
  function automatic logic [IN_BITS-1:0] tt_bit(input logic [IN_BITS-1:0] idx);
    return IN_BITS'(TT_BITS - 1) - idx;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Counts cycles while enabled; expire flags the last cycle of a settle interval.
module settle_timer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through all 8 input combinations, samples its output
// after each settle interval and compares the assembled code with an expected one.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [TT_BITS-1:0] expected,
  output logic [IN_BITS-1:0] dut_in,
  input  logic               dut_out,
  output logic               busy,
  output logic               done,
  output logic [TT_BITS-1:0] tt_code,
  output logic               match
);

  tt_state_t          state, state_next;
  logic [IN_BITS-1:0] idx;
  logic [TT_BITS-1:0] expected_q;
  logic [TT_BITS-1:0] tt_code_next;
  logic               expire;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != SETTLE),
    .enable(state == SETTLE),
    .expire(expire)
  );

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    tt_code_next = tt_code;
    if (state == SAMPLE) begin
      tt_code_next[tt_bit(idx)] = dut_out;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (abort) state_next = IDLE;
               else if (expire) state_next = SAMPLE;
      SAMPLE:  if (abort) state_next = IDLE;
               else if (idx == IN_BITS'(TT_BITS - 1)) state_next = DONE;
               else state_next = SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      tt_code    <= '0;
      match      <= 1'b0;
      expected_q <= '0;
    end else begin
      state   <= state_next;
      tt_code <= tt_code_next;
      if (state == IDLE && start) begin
        tt_code    <= '0;
        match      <= 1'b0;
        expected_q <= expected;
      end
      if (state == SAMPLE && state_next == SETTLE) begin
        idx <= idx + IN_BITS'(1);
      end
      // Leaving for IDLE (finish or abort) parks the gate inputs at 000.
      if (state_next == IDLE) begin
        idx <= '0;
      end
      // Compare against the code including the final capture made this cycle.
      if (state_next == DONE) begin
        match <= (tt_code_next == expected_q);
      end
    end
  end

  assign dut_in = idx;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised bench for truth_table_sweeper: a cycle-indexed reference model of
// the sweep (timing, dut_in sequence, captured bits) checks two builds.
module tb_truth_table_sweeper;

  localparam int SA   = 4;
  localparam int SB   = 1;
  localparam int LA   = 8 * (SA + 1) + 1;
  localparam int LB   = 8 * (SB + 1) + 1;
  localparam int NMAX = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, abort_a = 1'b0, noise_a = 1'b0;
  logic [7:0] expected_a = 8'h00, gate_a = 8'h05;
  logic [2:0] dut_in_a;
  logic       dut_out_a, busy_a, done_a, match_a;
  logic [7:0] tt_code_a;

  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] expected_b = 8'h00, gate_b = 8'hFF;
  logic [2:0] dut_in_b;
  logic       dut_out_b, busy_b, done_b, match_b;
  logic [7:0] tt_code_b;

  // Gate tables are indexed by input combination; noise disturbs every cycle
  // except those in which the sweeper is expected to sample.
  assign dut_out_a = gate_a[dut_in_a] ^ noise_a;
  assign dut_out_b = gate_b[dut_in_b];

  truth_table_sweeper #(.SETTLE_CYCLES(SA), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .expected(expected_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .tt_code(tt_code_a), .match(match_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(SB), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .expected(expected_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .tt_code(tt_code_b), .match(match_b)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle observations; index n is the n-th cycle after the start edge.
  logic [2:0] din_tr  [NMAX];
  logic       busy_tr [NMAX];
  logic       done_tr [NMAX];
  logic       match_tr[NMAX];
  logic [7:0] tt_tr   [NMAX];

  // Code held after every sample whose cycle is at or before last_cycle.
  // Combination k is sampled in cycle (k+1)*(s+1) and stored at bit 7-k.
  function automatic logic [7:0] model_code(input logic [7:0] tbl, input int last_cycle,
                                            input int s);
    logic [7:0] c;
    c = 8'h00;
    for (int k = 0; k < 8; k++)
      if ((k + 1) * (s + 1) <= last_cycle) c[7 - k] = tbl[k];
    return c;
  endfunction

  function automatic int count_done();
    int cnt;
    cnt = 0;
    for (int n = 1; n < NMAX; n++) if (done_tr[n]) cnt++;
    return cnt;
  endfunction

  task automatic sweep_a(input logic [7:0] exp, input int abort_at, input int restart_at,
                         input int reset_at, input bit use_noise, input bit abort_on_start);
    @(negedge clk);
    start_a    = 1'b1;
    abort_a    = abort_on_start;
    expected_a = exp;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    for (int n = 1; n < NMAX; n++) begin
      din_tr[n]   = dut_in_a;
      busy_tr[n]  = busy_a;
      done_tr[n]  = done_a;
      match_tr[n] = match_a;
      tt_tr[n]    = tt_code_a;
      abort_a = (n == abort_at);
      start_a = (n == restart_at);
      if (n == restart_at) expected_a = 8'hFF;
      rst_n   = (n != reset_at);
      noise_a = (use_noise && (n % (SA + 1) != 0)) ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    abort_a = 1'b0;
    start_a = 1'b0;
    noise_a = 1'b0;
    rst_n   = 1'b1;
  endtask

  task automatic sweep_b(input logic [7:0] exp);
    @(negedge clk);
    start_b    = 1'b1;
    expected_b = exp;
    @(negedge clk);
    start_b = 1'b0;
    for (int n = 1; n < NMAX; n++) begin
      din_tr[n]   = dut_in_b;
      busy_tr[n]  = busy_b;
      done_tr[n]  = done_b;
      match_tr[n] = match_b;
      tt_tr[n]    = tt_code_b;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({dut_in_a, busy_a, done_a, tt_code_a, match_a} !== 14'd0) begin
      errors++;
      $display("FAIL reset_a: got dut_in=%0d busy=%b done=%b tt=%h match=%b want all zero",
               dut_in_a, busy_a, done_a, tt_code_a, match_a);
    end
    checks++;
    if ({dut_in_b, busy_b, done_b, tt_code_b, match_b} !== 14'd0) begin
      errors++;
      $display("FAIL reset_b: got dut_in=%0d busy=%b done=%b tt=%h match=%b want all zero",
               dut_in_b, busy_b, done_b, tt_code_b, match_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [7:0] code, exp;
    int bad;
    for (int t = 0; t < 10; t++) begin
      gate_a = (t < 2) ? 8'b0000_0101 : 8'($urandom);
      code   = model_code(gate_a, NMAX, SA);
      if (t == 0)      exp = 8'hA0;
      else if (t == 1) exp = 8'hA1;
      else             exp = $urandom_range(0, 1) ? code : 8'($urandom);
      sweep_a(exp, -1, -1, -1, t >= 2, 1'b0);
      checks++;
      if (count_done() != 1 || done_tr[LA] !== 1'b1) begin
        errors++;
        $display("FAIL done_latency[%0d]: got %0d pulses, done@%0d=%b want one pulse at %0d",
                 t, count_done(), LA, done_tr[LA], LA);
      end
      checks++;
      if (tt_tr[LA] !== code) begin
        errors++;
        $display("FAIL tt_code[%0d]: got %h want %h", t, tt_tr[LA], code);
      end
      checks++;
      if (match_tr[LA] !== (code == exp)) begin
        errors++;
        $display("FAIL match[%0d]: got %b want %b", t, match_tr[LA], code == exp);
      end
      bad = 0;
      for (int n = 1; n <= LA + 2; n++) if (busy_tr[n] !== (n <= LA)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL busy_window[%0d]: got %0d wrong cycles want 0", t, bad);
      end
      checks++;
      if (match_tr[LA + 5] !== (code == exp) || tt_tr[LA + 5] !== code) begin
        errors++;
        $display("FAIL result_hold[%0d]: got tt=%h match=%b want tt=%h match=%b",
                 t, tt_tr[LA + 5], match_tr[LA + 5], code, code == exp);
      end
    end
  endtask

  task automatic test_dut_in_sequence();
    int bad;
    gate_a = 8'b0000_0101;
    sweep_a(8'hA0, -1, -1, -1, 1'b1, 1'b0);
    bad = 0;
    for (int n = 1; n <= 8 * (SA + 1); n++)
      if (din_tr[n] !== 3'((n - 1) / (SA + 1))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL dut_in_sequence: got %0d wrong cycles want 0", bad);
    end
    checks++;
    if (din_tr[LA + 1] !== 3'd0) begin
      errors++;
      $display("FAIL dut_in_idle: got %0d want 0", din_tr[LA + 1]);
    end
  endtask

  task automatic test_abort();
    int ab, bad;
    logic [7:0] part;
    for (int t = 0; t < 5; t++) begin
      ab = (t == 0) ? 20 : (t == 1) ? 8 * (SA + 1) : $urandom_range(1, 8 * (SA + 1));
      gate_a = 8'($urandom);
      part   = model_code(gate_a, ab, SA);
      sweep_a(8'h00, ab, -1, -1, 1'b1, 1'b0);
      checks++;
      if (count_done() != 0) begin
        errors++;
        $display("FAIL abort_no_done[%0d]: got %0d pulses want 0", ab, count_done());
      end
      bad = 0;
      for (int n = 1; n <= ab + 1; n++) if (busy_tr[n] !== (n <= ab)) bad++;
      checks++;
      if (bad != 0 || din_tr[ab + 1] !== 3'd0) begin
        errors++;
        $display("FAIL abort_idle[%0d]: got busy errs=%0d dut_in=%0d want 0 and 0",
                 ab, bad, din_tr[ab + 1]);
      end
      checks++;
      if (tt_tr[ab + 1] !== part || match_tr[ab + 1] !== 1'b0) begin
        errors++;
        $display("FAIL abort_partial[%0d]: got tt=%h match=%b want tt=%h match=0",
                 ab, tt_tr[ab + 1], match_tr[ab + 1], part);
      end
    end
    // abort during DONE is ignored, and abort alongside start in IDLE loses to start
    for (int t = 0; t < 2; t++) begin
      gate_a = 8'($urandom);
      sweep_a(model_code(gate_a, NMAX, SA), (t == 0) ? LA : -1, -1, -1, 1'b0, t == 1);
      checks++;
      if (count_done() != 1 || done_tr[LA] !== 1'b1 || match_tr[LA] !== 1'b1) begin
        errors++;
        $display("FAIL abort_ignored[%0d]: got pulses=%0d done@%0d=%b match=%b want 1 1 1",
                 t, count_done(), LA, done_tr[LA], match_tr[LA]);
      end
    end
  endtask

  task automatic test_back_to_back_start();
    int rs;
    for (int t = 0; t < 2; t++) begin
      rs = (t == 0) ? 15 : LA;
      gate_a = 8'b0000_0101;
      sweep_a(8'hA0, -1, rs, -1, 1'b0, 1'b0);
      checks++;
      if (count_done() != 1 || done_tr[LA] !== 1'b1 || match_tr[LA] !== 1'b1) begin
        errors++;
        $display("FAIL start_ignored[%0d]: got pulses=%0d done=%b match=%b want 1 1 1",
                 rs, count_done(), done_tr[LA], match_tr[LA]);
      end
      checks++;
      if (busy_tr[LA + 1] !== 1'b0) begin
        errors++;
        $display("FAIL start_ignored_busy[%0d]: got %b want 0", rs, busy_tr[LA + 1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    gate_a = 8'b0000_0101;
    sweep_a(8'hA0, -1, -1, 12, 1'b0, 1'b0);
    checks++;
    if ({din_tr[13], busy_tr[13], done_tr[13], tt_tr[13], match_tr[13]} !== 14'd0
        || count_done() != 0) begin
      errors++;
      $display("FAIL reset_mid: got dut_in=%0d busy=%b tt=%h match=%b pulses=%0d want zeros",
               din_tr[13], busy_tr[13], tt_tr[13], match_tr[13], count_done());
    end
    sweep_a(8'hA0, -1, -1, -1, 1'b0, 1'b0);
    checks++;
    if (count_done() != 1 || done_tr[LA] !== 1'b1 || tt_tr[LA] !== 8'hA0) begin
      errors++;
      $display("FAIL reset_recover: got pulses=%0d done=%b tt=%h want 1 1 a0",
               count_done(), done_tr[LA], tt_tr[LA]);
    end
  endtask

  task automatic test_short_settle();
    logic [7:0] code;
    int bad;
    for (int t = 0; t < 3; t++) begin
      gate_b = (t == 0) ? 8'hFF : 8'($urandom);
      code   = model_code(gate_b, NMAX, SB);
      sweep_b((t == 0) ? 8'hFF : code ^ 8'(t - 1));
      checks++;
      if (count_done() != 1 || done_tr[LB] !== 1'b1) begin
        errors++;
        $display("FAIL short_latency[%0d]: got pulses=%0d done@%0d=%b want 1 pulse at %0d",
                 t, count_done(), LB, done_tr[LB], LB);
      end
      checks++;
      if (tt_tr[LB] !== code || match_tr[LB] !== (t != 2)) begin
        errors++;
        $display("FAIL short_code[%0d]: got tt=%h match=%b want tt=%h match=%b",
                 t, tt_tr[LB], match_tr[LB], code, t != 2);
      end
      bad = 0;
      for (int n = 1; n <= 8 * (SB + 1); n++)
        if (din_tr[n] !== 3'((n - 1) / (SB + 1))) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL short_dut_in[%0d]: got %0d wrong cycles want 0", t, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_dut_in_sequence();
    test_abort();
    test_back_to_back_start();
    test_reset_mid();
    test_short_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
